// File: rtl/serial_full_adder_if.sv
// serial_full_adder_if: operand/result handshake bundle for serial_full_adder
// ovf exists only when SERIAL_ADDER_OVF_EN is defined
interface serial_full_adder_if #(parameter int WIDTH = 8);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;
   modport master (output in_valid, a, b, cin, out_ready,
                   input in_ready, out_valid, sum, cout, busy, ovf);
   modport slave (input in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, busy, ovf);
`else
   modport master (output in_valid, a, b, cin, out_ready,
                   input in_ready, out_valid, sum, cout, busy);
   modport slave (input in_valid, a, b, cin, out_ready,
                  output in_ready, out_valid, sum, cout, busy);
`endif
endinterface

// File: rtl/serial_full_adder.sv
// serial_full_adder: bit-serial LSB-first adder, one full-adder cell plus carry FF
// Optional signed-overflow output enabled by SERIAL_ADDER_OVF_EN
module serial_full_adder #(
   parameter int WIDTH = 8
) (
   input logic               clk,
   input logic               rst_n,
   serial_full_adder_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_r;
   logic [CW-1:0]    cnt;
   logic             c;
   logic             cout_r;
   logic             s;
   logic             c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_r;
   assign bus.ovf = ovf_r;
`endif
   assign s = a_sh[0] ^ b_sh[0] ^ c;
   assign c_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
   assign bus.in_ready = (state == IDLE) & rst_n;
   assign bus.out_valid = state == DONE;
   assign bus.busy = state != IDLE;
   assign bus.sum = sum_r;
   assign bus.cout = cout_r;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         sum_r  <= '0;
         cnt    <= '0;
         c      <= 1'b0;
         cout_r <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_r  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               a_sh  <= bus.a;
               b_sh  <= bus.b;
               c     <= bus.cin;
               cnt   <= '0;
               state <= RUN;
            end
            RUN: begin
               sum_r <= {s, sum_r[WIDTH-1:1]};
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               c     <= c_nxt;
               cnt   <= (cnt == LAST) ? cnt : cnt + 1'b1;
               if (cnt == LAST) begin
                  state  <= DONE;
                  cout_r <= c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
                  // c is the carry into the MSB on the final bit step
                  ovf_r  <= c ^ c_nxt;
`endif
               end
            end
            DONE: if (bus.out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_full_adder.sv
// tb_serial_full_adder: scoreboard bench for serial_full_adder (WIDTH=8)
// ovf checks compile in only with SERIAL_ADDER_OVF_EN
module tb_serial_full_adder;
   localparam int W = 8;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int prev_acc = 0;
   bit have_prev = 1'b0;
   logic [W+1:0] sb[$];
   serial_full_adder_if #(.WIDTH(W)) bus ();
   serial_full_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci);
      logic [W:0] s;
      logic ov;
      s = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
      ov = (av[W-1] == bv[W-1]) && (s[W-1] != av[W-1]);
      return {ov, s};
   endfunction

   task automatic check_result(input string tag, input logic [W+1:0] e);
      check({tag, "_sum"}, 64'(bus.sum), 64'(e[W-1:0]));
      check({tag, "_cout"}, 64'(bus.cout), 64'(e[W]));
`ifdef SERIAL_ADDER_OVF_EN
      check({tag, "_ovf"}, 64'(bus.ovf), 64'(e[W+1]));
`endif
   endtask

   task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                        input int hold, input bit b2b);
      int n;
      logic [W+1:0] e;
      check("idle_in_ready", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.a = av;
      bus.b = bv;
      bus.cin = ci;
      bus.out_ready = (hold == 0);
      @(posedge clk); #1;
      if (b2b && have_prev) check("b2b_spacing", 64'(cyc - prev_acc), 64'(W + 2));
      prev_acc = cyc;
      have_prev = b2b;
      sb.push_back(model(av, bv, ci));
      if (!b2b) bus.in_valid = 1'b0;
      check("run_in_ready", 64'(bus.in_ready), 64'd0);
      check("run_busy", 64'(bus.busy), 64'd1);
      n = 0;
      while (!bus.out_valid && n < W + 4) begin
         @(posedge clk); #1;
         n++;
      end
      check("latency", 64'(n), 64'(W));
      e = sb.pop_front();
      for (int i = 0; i < hold; i++) begin
         check("hold_valid", 64'(bus.out_valid), 64'd1);
         check("hold_in_ready", 64'(bus.in_ready), 64'd0);
         check_result("hold", e);
         bus.in_valid = (i == 2);
         bus.a = 8'hAA;
         bus.b = 8'h99;
         @(posedge clk); #1;
      end
      if (hold > 0) begin
         bus.in_valid = 1'b0;
         bus.out_ready = 1'b1;
      end
      check("done_busy", 64'(bus.busy), 64'd1);
      check_result("res", e);
      @(posedge clk); #1;
      check("valid_drop", 64'(bus.out_valid), 64'd0);
      check("back_idle", 64'(bus.in_ready), 64'd1);
   endtask

   initial begin
      int seen;
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.cin = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'd0);
      check("rst_valid", 64'(bus.out_valid), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_sum", 64'(bus.sum), 64'd0);
      check("rst_cout", 64'(bus.cout), 64'd0);
      rst_n = 1'b1;
      #1;
      do_op(8'h3C, 8'h05, 1'b0, 0, 1'b0);
      do_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
      do_op(8'h00, 8'h00, 1'b1, 0, 1'b0);
      do_op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
      do_op(8'h80, 8'h80, 1'b0, 0, 1'b0);
      do_op(8'h5A, 8'hA5, 1'b1, 5, 1'b0);
      // abort a transfer after three bit steps
      bus.in_valid = 1'b1;
      bus.a = 8'hF0;
      bus.b = 8'h0F;
      bus.cin = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      sb.push_back(model(8'hF0, 8'h0F, 1'b1));
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      void'(sb.pop_back());
      check("midrst_valid", 64'(bus.out_valid), 64'd0);
      check("midrst_sum", 64'(bus.sum), 64'd0);
      check("midrst_busy", 64'(bus.busy), 64'd0);
      check("midrst_cout", 64'(bus.cout), 64'd0);
      seen = 0;
      for (int i = 0; i < W + 2; i++) begin
         @(posedge clk); #1;
         seen += int'(bus.out_valid);
      end
      check("midrst_no_pulse", 64'(seen), 64'd0);
      do_op(8'h12, 8'h34, 1'b0, 0, 1'b0);
      do_op(8'h11, 8'h22, 1'b0, 0, 1'b1);
      do_op(8'hC8, 8'h64, 1'b1, 0, 1'b1);
      do_op(8'h81, 8'hFE, 1'b0, 0, 1'b1);
      bus.in_valid = 1'b0;
      for (int i = 0; i < 6; i++)
         do_op(W'($urandom), W'($urandom), 1'($urandom), 0, 1'b0);
      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
